ezm_prog_feeder: RTL and testbench

- Program-memory responder for the 8-bit EZM accumulator CPU.
- Holds a loadable program of two-word instructions: a 6-bit opcode word followed by a 6-bit operand word.
- Watches the CPU's multiplexed output and serves the CPU's 6-bit instruction input: the opcode word in the fetch phase, the operand word in the execute phase.
- Controls the CPU reset, captures the accumulator trace, and halts on end-of-program or on a step limit.

---
 rtl/ezm_prog_feeder.sv | 105 ++++++++++
 tb/tb_ezm_prog_feeder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ezm_prog_feeder.sv
// Program-memory responder for the 8-bit EZM accumulator CPU: serves opcode/operand
// words in lockstep with the CPU's fetch/execute rhythm and traces the accumulator.
module ezm_prog_feeder #(
  parameter int unsigned AW        = 4,
  parameter int unsigned MAX_STEPS = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW:0]   prog_addr,
  input  logic [5:0]    prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          run,
  input  logic [7:0]    cpu_out_i,
  output logic [5:0]    cpu_in_o,
  output logic          cpu_rst_o,
  output logic [7:0]    acc_o,
  output logic          acc_valid_o,
  output logic          busy_o,
  output logic          halted_o,
  output logic          timeout_o
);

  localparam int unsigned DEPTH = 2 ** (AW + 1);
  localparam int unsigned SW    = $clog2(MAX_STEPS + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t        state;
  logic [5:0]    mem [DEPTH];
  logic [SW-1:0] step_q;
  logic [AW:0]   len_q;
  logic [AW-1:0] pc_q;
  logic          ctl_state;
  logic          prog_end;
  logic          step_limit;

  assign ctl_state  = (state == S_IDLE) || (state == S_HALT);
  assign prog_end   = cpu_out_i >= 8'(len_q);
  assign step_limit = step_q == SW'(MAX_STEPS);
  assign busy_o     = (state == S_FETCH) || (state == S_EXEC);
  assign halted_o   = (state == S_HALT);

  // Program store; survives rst so a reset CPU can be rerun on the same program.
  always_ff @(posedge clk) begin
    if (prog_we && ctl_state) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Word served to the CPU this cycle; zero whenever the CPU is not being fed.
  always_comb begin
    cpu_in_o = 6'd0;
    case (state)
      S_FETCH: if (!prog_end && !step_limit) cpu_in_o = mem[{cpu_out_i[AW-1:0], 1'b0}];
      S_EXEC:  cpu_in_o = mem[{pc_q, 1'b1}];
      default: cpu_in_o = 6'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cpu_rst_o   <= 1'b1;
      acc_o       <= 8'd0;
      acc_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
      step_q      <= '0;
      len_q       <= '0;
      pc_q        <= '0;
    end else begin
      acc_valid_o <= 1'b0;
      case (state)
        S_IDLE, S_HALT: begin
          if (run) begin
            len_q     <= prog_len;
            step_q    <= '0;
            timeout_o <= 1'b0;
            cpu_rst_o <= 1'b0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          // End-of-program wins over the step limit, so timeout only flags a true runaway.
          if (prog_end || step_limit) begin
            state     <= S_HALT;
            cpu_rst_o <= 1'b1;
            timeout_o <= !prog_end;
          end else begin
            pc_q   <= cpu_out_i[AW-1:0];
            step_q <= step_q + SW'(1);
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc_o       <= cpu_out_i;
          acc_valid_o <= 1'b1;
          state       <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ezm_prog_feeder.sv
// Directed bench for ezm_prog_feeder; the bench plays the CPU by driving cpu_out_i
// with PC in fetch phases and the accumulator in execute phases.
module tb_ezm_prog_feeder;

  localparam int unsigned AW = 4;

  logic        clk = 1'b0;
  logic        rst, prog_we, run;
  logic [AW:0] prog_addr, prog_len;
  logic [5:0]  prog_data, cpu_in_o;
  logic [7:0]  cpu_out_i, acc_o;
  logic        cpu_rst_o, acc_valid_o, busy_o, halted_o, timeout_o;

  int checks   = 0;
  int failures = 0;

  ezm_prog_feeder #(.AW(AW), .MAX_STEPS(4)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .run(run), .cpu_out_i(cpu_out_i),
    .cpu_in_o(cpu_in_o), .cpu_rst_o(cpu_rst_o), .acc_o(acc_o), .acc_valid_o(acc_valid_o),
    .busy_o(busy_o), .halted_o(halted_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [AW:0] a, input logic [5:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic start(input logic [AW:0] len);
    prog_len = len; run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (cpu_rst_o !== 1'b1) begin failures++; $display("FAIL reset_cpu_rst got=%b exp=1", cpu_rst_o); end
    checks++; if (acc_o !== 8'h00) begin failures++; $display("FAIL reset_acc got=%h exp=00", acc_o); end
    checks++; if ({busy_o, halted_o, timeout_o, acc_valid_o} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {busy_o, halted_o, timeout_o, acc_valid_o}); end
    checks++; if (cpu_in_o !== 6'h00) begin failures++; $display("FAIL reset_cpu_in got=%h exp=00", cpu_in_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_start();
    prog_write(5'd0, 6'h20);
    prog_write(5'd1, 6'h05);
    start(5'd1);
    checks++; if ({busy_o, cpu_rst_o} !== 2'b10) begin failures++; $display("FAIL ls_running got=%b exp=10", {busy_o, cpu_rst_o}); end
    cpu_out_i = 8'd0; #1;
    checks++; if (cpu_in_o !== 6'h20) begin failures++; $display("FAIL ls_opcode got=%h exp=20", cpu_in_o); end
    tick();
    cpu_out_i = 8'h00; #1;
    checks++; if (cpu_in_o !== 6'h05) begin failures++; $display("FAIL ls_operand got=%h exp=05", cpu_in_o); end
    tick();
    checks++; if ({acc_valid_o, acc_o} !== {1'b1, 8'h00}) begin failures++; $display("FAIL ls_acc got=%b/%h exp=1/00", acc_valid_o, acc_o); end
    cpu_out_i = 8'd1; #1;
    checks++; if (cpu_in_o !== 6'h00) begin failures++; $display("FAIL ls_end_word got=%h exp=00", cpu_in_o); end
    tick();
    checks++; if ({halted_o, cpu_rst_o, busy_o, timeout_o} !== 4'b1100) begin failures++; $display("FAIL ls_halt got=%b exp=1100", {halted_o, cpu_rst_o, busy_o, timeout_o}); end
  endtask

  task automatic test_two_loads();
    prog_write(5'd2, 6'h20);
    prog_write(5'd3, 6'h1F);
    start(5'd2);
    cpu_out_i = 8'd0; tick();
    cpu_out_i = 8'h00; tick();
    cpu_out_i = 8'd1; #1;
    checks++; if (cpu_in_o !== 6'h20) begin failures++; $display("FAIL tl_opcode1 got=%h exp=20", cpu_in_o); end
    tick();
    cpu_out_i = 8'h05; #1;
    checks++; if (cpu_in_o !== 6'h1F) begin failures++; $display("FAIL tl_operand1 got=%h exp=1F", cpu_in_o); end
    tick();
    checks++; if ({acc_valid_o, acc_o} !== {1'b1, 8'h05}) begin failures++; $display("FAIL tl_acc got=%b/%h exp=1/05", acc_valid_o, acc_o); end
    cpu_out_i = 8'd2; tick();
    checks++; if ({halted_o, timeout_o} !== 2'b10) begin failures++; $display("FAIL tl_halt got=%b exp=10", {halted_o, timeout_o}); end
    checks++; if (acc_o !== 8'h05) begin failures++; $display("FAIL tl_acc_kept got=%h exp=05", acc_o); end
  endtask

  task automatic test_runaway();
    int  execs = 0;
    bit  phase = 1'b0;
    start(5'd2);
    for (int i = 0; i < 20; i++) begin
      if (halted_o) break;
      if (acc_valid_o) execs++;
      cpu_out_i = phase ? 8'h11 : 8'h00;
      tick();
      phase = ~phase;
    end
    checks++; if (execs != 4) begin failures++; $display("FAIL rw_exec_count got=%0d exp=4", execs); end
    checks++; if ({halted_o, timeout_o, cpu_rst_o} !== 3'b111) begin failures++; $display("FAIL rw_timeout got=%b exp=111", {halted_o, timeout_o, cpu_rst_o}); end
  endtask

  task automatic test_write_lockout();
    start(5'd1);
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL wl_timeout_clear got=%b exp=0", timeout_o); end
    cpu_out_i = 8'd0; tick();
    prog_we = 1'b1; prog_addr = 5'd1; prog_data = 6'h3F; cpu_out_i = 8'h00;
    tick();
    prog_we = 1'b0;
    cpu_out_i = 8'd1; tick();
    start(5'd1);
    cpu_out_i = 8'd0; tick();
    #1;
    checks++; if (cpu_in_o !== 6'h05) begin failures++; $display("FAIL wl_readback got=%h exp=05", cpu_in_o); end
    cpu_out_i = 8'd1; tick();
    tick();
  endtask

  task automatic test_reset_mid_run();
    start(5'd2);
    cpu_out_i = 8'd0; tick();
    cpu_out_i = 8'h42; tick();
    checks++; if (acc_o !== 8'h42) begin failures++; $display("FAIL rm_acc_before got=%h exp=42", acc_o); end
    cpu_out_i = 8'd1; tick();
    rst = 1'b1; cpu_out_i = 8'h77;
    tick();
    rst = 1'b0;
    checks++; if ({cpu_rst_o, busy_o, halted_o, acc_valid_o} !== 4'b1000) begin failures++; $display("FAIL rm_flags got=%b exp=1000", {cpu_rst_o, busy_o, halted_o, acc_valid_o}); end
    checks++; if (acc_o !== 8'h00) begin failures++; $display("FAIL rm_acc got=%h exp=00", acc_o); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pcs [5] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2};
    logic [5:0] ops [5] = '{6'h20, 6'h2A, 6'h20, 6'h2A, 6'h00};
    logic [5:0] opd [5] = '{6'h05, 6'h1F, 6'h05, 6'h1F, 6'h00};
    // Write and run in one cycle: the write must land before instruction 1 is fetched.
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 6'h2A;
    start(5'd2);
    prog_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cpu_out_i = pcs[i]; #1;
      checks++; if (cpu_in_o !== ops[i]) begin failures++; $display("FAIL bb_opcode%0d got=%h exp=%h", i, cpu_in_o, ops[i]); end
      tick();
      if (i < 4) begin
        cpu_out_i = 8'(i); #1;
        checks++; if (cpu_in_o !== opd[i]) begin failures++; $display("FAIL bb_operand%0d got=%h exp=%h", i, cpu_in_o, opd[i]); end
        tick();
      end
    end
    checks++; if ({halted_o, timeout_o, cpu_rst_o} !== 3'b101) begin failures++; $display("FAIL bb_halt got=%b exp=101", {halted_o, timeout_o, cpu_rst_o}); end
    checks++; if (acc_o !== 8'd3) begin failures++; $display("FAIL bb_acc got=%h exp=03", acc_o); end
  endtask

  task automatic test_run_ignored();
    start(5'd2);
    cpu_out_i = 8'd0; run = 1'b1; prog_len = 5'd0;
    tick();
    run = 1'b0;
    checks++; if ({busy_o, halted_o} !== 2'b10) begin failures++; $display("FAIL ri_busy got=%b exp=10", {busy_o, halted_o}); end
    cpu_out_i = 8'h00; tick();
    cpu_out_i = 8'd1; #1;
    checks++; if (cpu_in_o !== 6'h2A) begin failures++; $display("FAIL ri_len_kept got=%h exp=2A", cpu_in_o); end
    tick();
    cpu_out_i = 8'h00; tick();
    cpu_out_i = 8'd2; tick();
    checks++; if (halted_o !== 1'b1) begin failures++; $display("FAIL ri_halt got=%b exp=1", halted_o); end
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; run = 1'b0;
    prog_addr = '0; prog_data = '0; prog_len = '0; cpu_out_i = '0;
    test_reset();
    test_load_start();
    test_two_loads();
    test_runaway();
    test_write_lockout();
    test_reset_mid_run();
    test_back_to_back();
    test_run_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
